// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a per-register
// pending (scoreboard) bit and a registered count of pending registers.
// Register 0 is hardwired to zero and is never pending.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data (and the resulting pending state) straight to the read ports.
// Without it, reads see stored state only.

module regfile_mp #(
    parameter int WIDTH       = 32,
    parameter int ADDR_W      = 5,
    parameter int READ_PORTS  = 3,
    parameter int WRITE_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [READ_PORTS*ADDR_W-1:0]  ra,
    output logic [READ_PORTS*WIDTH-1:0]   rd,
    output logic [READ_PORTS-1:0]         rbusy,
    input  logic [WRITE_PORTS-1:0]        wen,
    input  logic [WRITE_PORTS*ADDR_W-1:0] wa,
    input  logic [WRITE_PORTS*WIDTH-1:0]  wd,
    input  logic                          alloc_en,
    input  logic [ADDR_W-1:0]             alloc_addr,
    output logic [ADDR_W:0]               busy_cnt
);

    localparam int             DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

    // Architectural state. Entry 0 of both arrays is held at zero.
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [ADDR_W:0]   cnt_q;

    // Per-entry decode of this cycle's writes and allocation.
    logic [DEPTH-1:0]  wr_hit;
    logic [WIDTH-1:0]  wr_data [DEPTH];
    logic [DEPTH-1:0]  alloc_hit;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   cnt_dec;

    // Decode write ports into per-entry strobes; later ports overwrite
    // earlier ones so the highest-index port wins a collision.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so the block stays purely combinational (no latches).
        wr_hit = '0;
        for (int e = 0; e < DEPTH; e++) begin
            wr_data[e] = '0;
        end
        for (int j = 0; j < WRITE_PORTS; j++) begin
            if (wen[j] && (wa[j*ADDR_W +: ADDR_W] != '0)) begin
                wr_hit[wa[j*ADDR_W +: ADDR_W]]  = 1'b1;
                wr_data[wa[j*ADDR_W +: ADDR_W]] = wd[j*WIDTH +: WIDTH];
            end
        end
    end

    // Decode the allocation and form the next pending vector; allocation
    // is applied after write clears so it wins on the same address.
    always_comb begin
        alloc_hit = '0;
        if (alloc_en && (alloc_addr != '0)) begin
            alloc_hit[alloc_addr] = 1'b1;
        end
        busy_nxt = (busy_q & ~wr_hit) | alloc_hit;
    end

    // Incremental count update: +1 for a fresh allocation, -1 for each
    // distinct entry whose pending flag falls this cycle.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        if (|(alloc_hit & ~busy_q)) begin
            cnt_inc = CNT_ONE;
        end
        for (int e = 1; e < DEPTH; e++) begin
            if (busy_q[e] && !busy_nxt[e]) begin
                cnt_dec = cnt_dec + CNT_ONE;
            end
        end
    end

    // Data storage; committed writes land on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage array is reset explicitly because reset must
            // make every register read back as zero, not just the control.
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // entries update together from values sampled before the edge.
            for (int e = 1; e < DEPTH; e++) begin
                if (wr_hit[e]) begin
                    mem[e] <= wr_data[e];
                end
            end
        end
    end

    // Pending flags and their running count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
            cnt_q  <= cnt_q + cnt_inc - cnt_dec;
        end
    end

    assign busy_cnt = cnt_q;

    // Combinational read ports; register 0 and a held reset read as zero.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            if (rst_n && (ra[i*ADDR_W +: ADDR_W] != '0)) begin
                rd[i*WIDTH +: WIDTH] = mem[ra[i*ADDR_W +: ADDR_W]];
                rbusy[i]             = busy_q[ra[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
                // Forward a same-cycle write; the last matching port wins.
                // The register is about to be released unless it is also
                // being re-allocated this cycle.
                for (int j = 0; j < WRITE_PORTS; j++) begin
                    if (wen[j] && (wa[j*ADDR_W +: ADDR_W] == ra[i*ADDR_W +: ADDR_W])) begin
                        rd[i*WIDTH +: WIDTH] = wd[j*WIDTH +: WIDTH];
                        rbusy[i] = alloc_en && (alloc_addr == ra[i*ADDR_W +: ADDR_W]);
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by random
// traffic, compared against an array-based reference model of the register
// file and its pending flags.

module tb_regfile_mp;

    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int RP    = 3;
    localparam int WP    = 2;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [RP*AW-1:0]  ra;
    logic [RP*W-1:0]   rd;
    logic [RP-1:0]     rbusy;
    logic [WP-1:0]     wen;
    logic [WP*AW-1:0]  wa;
    logic [WP*W-1:0]   wd;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic [AW:0]       busy_cnt;

    always #5 clk = ~clk;

    regfile_mp #(
        .WIDTH      (W),
        .ADDR_W     (AW),
        .READ_PORTS (RP),
        .WRITE_PORTS(WP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra        (ra),
        .rd        (rd),
        .rbusy     (rbusy),
        .wen       (wen),
        .wa        (wa),
        .wd        (wd),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .busy_cnt  (busy_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural contents and pending flags.
    logic [W-1:0] m_data [DEPTH];
    bit           m_busy [DEPTH];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < DEPTH; e++) begin
            m_data[e] = '0;
            m_busy[e] = 1'b0;
        end
    endtask

    // One clock edge worth of architectural effect, applied in port order
    // so the later port's data survives, allocation applied last.
    task automatic model_update();
        for (int j = 0; j < WP; j++) begin
            if (wen[j] && wa[j*AW +: AW] != 0) begin
                m_data[wa[j*AW +: AW]] = wd[j*W +: W];
                m_busy[wa[j*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    endtask

    function automatic int model_count();
        int n = 0;
        for (int e = 0; e < DEPTH; e++) n += int'(m_busy[e]);
        return n;
    endfunction

    task automatic exp_read(input logic [AW-1:0] a, output logic [W-1:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (rst_n && a != 0) begin
            d = m_data[a];
            b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < WP; j++) begin
                if (wen[j] && wa[j*AW +: AW] == a) begin
                    d = wd[j*W +: W];
                    b = alloc_en && (alloc_addr == a);
                end
            end
`endif
        end
    endtask

    task automatic check_reads(input string tag);
        logic [W-1:0] d;
        logic         b;
        for (int i = 0; i < RP; i++) begin
            exp_read(ra[i*AW +: AW], d, b);
            check($sformatf("%s_rd%0d", tag, i), rd[i*W +: W], d);
            check($sformatf("%s_rbusy%0d", tag, i), W'(rbusy[i]), W'(b));
        end
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_busy_cnt"}, W'(busy_cnt), W'(model_count()));
    endtask

    task automatic idle();
        wen        = '0;
        wa         = '0;
        wd         = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
    endtask

    task automatic set_ra(input int i, input logic [AW-1:0] a);
        ra[i*AW +: AW] = a;
    endtask

    task automatic set_wr(input int j, input logic en, input logic [AW-1:0] a, input logic [W-1:0] d);
        wen[j]         = en;
        wa[j*AW +: AW] = a;
        wd[j*W +: W]   = d;
    endtask

    task automatic set_alloc(input logic en, input logic [AW-1:0] a);
        alloc_en   = en;
        alloc_addr = a;
    endtask

    // Apply the currently driven inputs at the next rising edge; return at
    // the following falling edge with inputs still unchanged.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        ra    = '0;
        idle();
        model_reset();

        // Reset held: everything reads zero.
        set_ra(0, 5);
        set_ra(1, 3);
        #12;
        check_reads("rst_hold");
        check_cnt("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Write x5 and allocate x6, then assert reset mid-cycle with a write
        // and an allocation in flight.
        set_wr(0, 1'b1, 5, 32'hDEAD_BEEF);
        set_alloc(1'b1, 6);
        tick();
        idle();
        set_ra(0, 5);
        set_ra(1, 6);
        #1;
        check("x5_written", rd[0 +: W], 32'hDEAD_BEEF);
        check("x6_pending_cnt", W'(busy_cnt), 32'd1);
        set_wr(0, 1'b1, 5, 32'h0000_0001);
        set_alloc(1'b1, 8);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd", rd[0 +: W], 32'h0);
        check("async_rst_rbusy", W'(rbusy[1]), 32'h0);
        check("async_rst_cnt", W'(busy_cnt), 32'h0);
        model_reset();
        idle();
        #1;
        rst_n = 1'b1;
        set_ra(2, 8);
        tick();
        #1;
        check_reads("post_rst");
        check_cnt("post_rst");

        // Register 0 ignores writes and allocations.
        set_wr(0, 1'b1, 0, 32'h0000_1234);
        set_alloc(1'b1, 0);
        set_ra(0, 0);
        tick();
        idle();
        #1;
        check("x0_rd", rd[0 +: W], 32'h0);
        check("x0_rbusy", W'(rbusy[0]), 32'h0);
        check("x0_cnt", W'(busy_cnt), 32'h0);

        // Two ports write x7 in the same cycle: port 1 wins.
        set_wr(0, 1'b1, 7, 32'h11);
        set_wr(1, 1'b1, 7, 32'h22);
        tick();
        idle();
        set_ra(0, 7);
        #1;
        check("collision_x7", rd[0 +: W], 32'h22);

        // Scoreboard: allocate, re-allocate, then release x3.
        set_alloc(1'b1, 3);
        tick();
        idle();
        set_ra(0, 3);
        #1;
        check("alloc_x3_rbusy", W'(rbusy[0]), 32'h1);
        check("alloc_x3_cnt", W'(busy_cnt), 32'd1);
        set_alloc(1'b1, 3);
        tick();
        idle();
        #1;
        check("realloc_x3_cnt", W'(busy_cnt), 32'd1);
        set_wr(0, 1'b1, 3, 32'hAA);
        tick();
        idle();
        #1;
        check("release_x3_rbusy", W'(rbusy[0]), 32'h0);
        check("release_x3_rd", rd[0 +: W], 32'hAA);
        check("release_x3_cnt", W'(busy_cnt), 32'd0);

        // Allocate and write x9 together while it is already pending.
        set_alloc(1'b1, 9);
        tick();
        idle();
        #1;
        check("alloc_x9_cnt", W'(busy_cnt), 32'd1);
        set_alloc(1'b1, 9);
        set_wr(1, 1'b1, 9, 32'h99);
        tick();
        idle();
        set_ra(0, 9);
        #1;
        check("x9_still_pending", W'(rbusy[0]), 32'h1);
        check("x9_cnt", W'(busy_cnt), 32'd1);
        check("x9_data", rd[0 +: W], 32'h99);

        // Same-cycle write and read of x4.
        set_ra(0, 4);
        set_wr(0, 1'b1, 4, 32'h55);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_x4_same", rd[0 +: W], 32'h55);
`else
        check("bypass_x4_same", rd[0 +: W], 32'h0);
`endif
        check_reads("bypass_x4");
        tick();
        idle();
        #1;
        check("bypass_x4_next", rd[0 +: W], 32'h55);
        check_cnt("bypass_x4");

        // Random traffic with addresses biased toward a small window so
        // collisions, re-allocations and releases happen often.
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < WP; j++) begin
                set_wr(j, logic'($urandom_range(0, 1)), pick_addr(), $urandom);
            end
            set_alloc(logic'($urandom_range(0, 1)), pick_addr());
            for (int i = 0; i < RP; i++) begin
                set_ra(i, pick_addr());
            end
            #1;
            check_reads("rnd");
            tick();
            check_cnt("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register pending (scoreboard) bit. It replaces the single-write, two-read register file in the pipelined core. Decode uses it for operand fetch and RAW-hazard detection; the writeback stage(s) use it for result commit. Architectural register 0 is hardwired to zero and is never pending.

## Interface
Parameters:
- WIDTH, 32: data width of each register.
- ADDR_W, 5: address width; the file holds 2^ADDR_W entries, entry 0 included.
- READ_PORTS, 3: number of read ports (1..4).
- WRITE_PORTS, 2: number of write ports (1..2).

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous assert, active-low.
- ra  in  READ_PORTS*ADDR_W: read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd  out  READ_PORTS*WIDTH: read data, packed the same way as ra.
- rbusy  out  READ_PORTS: pending bit of each read address.
- wen  in  WRITE_PORTS: write enables.
- wa  in  WRITE_PORTS*ADDR_W: write addresses.
- wd  in  WRITE_PORTS*WIDTH: write data.
- alloc_en  in  1: mark register alloc_addr as pending (a destination was issued).
- alloc_addr  in  ADDR_W: register to allocate.
- busy_cnt  out  ADDR_W+1: number of registers currently pending.

## Operation
- Storage: entries 1..2^ADDR_W-1 each hold a WIDTH-bit data word and a 1-bit busy flag.
- Reset (rst_n=0, asynchronous): all data words go to 0, all busy flags go to 0, and busy_cnt goes to 0. While reset is held, rd and rbusy read as 0. If reset arrives mid-operation, any writes or allocations in flight are discarded.
- Read: combinational. For ra=0, rd=0 and rbusy=0. Otherwise, rd is the stored word and rbusy is the stored busy flag. Bypass behaviour is covered under Configuration.
- Write: when wen[j]=1 and wa[j]!=0, the entry takes wd[j] and its busy flag clears. Writes to address 0 are ignored.
- Write collision: when two ports target the same nonzero address in the same cycle, the higher-index port wins.
- Allocate: when alloc_en=1 and alloc_addr!=0, the entry's busy flag sets at the next edge.
- Allocate and write to the same address in the same cycle: allocation wins, so busy stays or becomes 1. The data word is still written.
- Allocating a register that is already pending is legal (WAW). It stays pending and busy_cnt is unchanged.
- A write to a register that is not pending is legal. Data is written and busy_cnt is unchanged.
- busy_cnt: registered. It always equals the population count of the busy vector after the same edge. It is updated incrementally: +1 for an allocation that turns a flag 0→1, and -1 for each distinct address whose flag turns 1→0. It can never exceed 2^ADDR_W-1.

## Timing
- Read latency: 0 cycles (combinational from ra and the stored state).
- Write latency: 1 edge. Without bypass, a read of the written address shows the new data in the cycle after wen.
- Allocate latency: 1 edge. rbusy rises in the cycle after alloc_en.
- busy_cnt: changes only on clock edges, and is consistent with rbusy in the same cycle.
- No handshakes; all inputs are sampled every cycle.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port whose nonzero address matches a same-cycle enabled write returns that wd, with the higher-index port winning on collision. Its rbusy reads 0, unless alloc_en targets the same address in that cycle, in which case rbusy reads 1. This gives a write-to-read path with zero cycles of latency.
- Undefined: reads return stored state only. A writeback reaches readers one cycle later. There is no combinational path from wd or wen to rd or rbusy.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse rst_n low between clock edges → rd(ra=5)=0 and busy_cnt=0 immediately, without waiting for an edge.
- x0 immutability: wen[0]=1, wa=0, wd=0x1234, alloc_en=1, alloc_addr=0 → rd(ra=0)=0, rbusy=0, busy_cnt=0.
- Collision: ports 0 and 1 both write x7 with 0x11 and 0x22 → next cycle rd(x7)=0x22.
- Scoreboard: allocate x3 → rbusy=1 and busy_cnt=1. Re-allocate x3 → busy_cnt=1. Write x3=0xAA → next cycle rbusy=0, rd=0xAA, busy_cnt=0.
- Simultaneous allocate and write of x9 (x9 pending, busy_cnt=1) → x9 still pending, busy_cnt=1, data updated.
- Bypass: write x4=0x55 while ra=4 in the same cycle. With REGFILE_BYPASS_EN → rd=0x55 in that cycle. Without it → rd shows the old value, then 0x55 the next cycle.
